// File: rtl/vmx_pkg.sv
// Shared definitions for the VMX processing-element array: lane modes and
// the default width of the weight-select countdown.
package vmx_pkg;

  typedef enum logic {
    MODE_FULL  = 1'b0,
    MODE_SIMD2 = 1'b1
  } vmx_mode_e;

  localparam int VMX_SEL_W  = 8;
  localparam int VMX_DATA_W = 16;

endpackage

// File: rtl/vmx_karatsuba_mul.sv
// Karatsuba partial-product stage: registers low/high/mid for one operand
// pair and exposes the cross term trim = mid - high - low to the next stage.
module vmx_karatsuba_mul #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] low,
  output logic [DATA_W-1:0] high,
  output logic [DATA_W:0]   trim
);

  localparam int H = DATA_W / 2;

  logic [H-1:0]      al, ah, bl, bh;
  logic [H:0]        a_sum, b_sum;
  logic [DATA_W+1:0] mid_q;
  logic [DATA_W+1:0] trim_full;
  logic              trim_unused;

  assign al    = a[H-1:0];
  assign ah    = a[DATA_W-1:H];
  assign bl    = b[H-1:0];
  assign bh    = b[DATA_W-1:H];
  assign a_sum = {1'b0, ah} + {1'b0, al};
  assign b_sum = {1'b0, bh} + {1'b0, bl};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low   <= '0;
      high  <= '0;
      mid_q <= '0;
    end else if (en) begin
      low   <= {{H{1'b0}}, al} * {{H{1'b0}}, bl};
      high  <= {{H{1'b0}}, ah} * {{H{1'b0}}, bh};
      mid_q <= {{(H+1){1'b0}}, a_sum} * {{(H+1){1'b0}}, b_sum};
    end
  end

  // ah*bl + al*bh always fits in DATA_W+1 bits, so the top bit is always zero.
  assign trim_full   = mid_q - {2'b00, high} - {2'b00, low};
  assign trim        = trim_full[DATA_W:0];
  assign trim_unused = trim_full[DATA_W+1];

endmodule

// File: rtl/vmx_pe_karatsuba_pipe.sv
// Systolic PE: forwards operands to the next PE, holds a stationary weight and
// accumulates data*weight onto the upstream partial sum through a 2-stage pipe.
module vmx_pe_karatsuba_pipe
  import vmx_pkg::*;
#(
  parameter int DATA_W = VMX_DATA_W,
  parameter int SEL_W  = VMX_SEL_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                simd_mode,
  input  logic [SEL_W-1:0]    is_weight,
  input  logic [DATA_W-1:0]   data,
  input  logic [2*DATA_W-1:0] sum_in,
  output logic                valid_pass,
  output logic                simd_mode_pass,
  output logic [SEL_W-1:0]    is_weight_pass,
  output logic [DATA_W-1:0]   data_pass,
  output logic [2*DATA_W-1:0] sum_out,
  output logic                sum_valid,
  output logic                weight_loaded
);

  localparam int H = DATA_W / 2;
  localparam logic [SEL_W-1:0] SEL_CAPTURE = {1'b1, {(SEL_W-1){1'b0}}};
  localparam logic [SEL_W-1:0] SEL_ONE     = {{(SEL_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]   weight_q;
  logic                capture;
  logic                s1_valid;
  vmx_mode_e           s1_mode;
  logic [2*DATA_W-1:0] s1_sum;
  logic [DATA_W-1:0]   prod_low, prod_high;
  logic [DATA_W:0]     prod_trim;
  logic [2*DATA_W-1:0] trim_wide;
  logic [2*DATA_W-1:0] full_sum;
  logic [DATA_W-1:0]   lane_lo, lane_hi;
  logic [2*DATA_W-1:0] sum_next;

  assign capture = in_valid && (is_weight == SEL_CAPTURE);

  // Countdown reaches the PE holding SEL_CAPTURE; the decrement hands the
  // next PE a value whose MSB is clear, so exactly one PE captures per load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_pass     <= 1'b0;
      simd_mode_pass <= 1'b0;
      is_weight_pass <= '0;
      data_pass      <= '0;
      weight_q       <= '0;
      weight_loaded  <= 1'b0;
    end else begin
      valid_pass     <= in_valid;
      simd_mode_pass <= simd_mode;
      data_pass      <= data;
      is_weight_pass <= in_valid ? (is_weight - SEL_ONE) : is_weight;
      if (capture) begin
        weight_q      <= data;
        weight_loaded <= 1'b1;
      end
    end
  end

  // The multiplier samples weight_q before a capture updates it.
  vmx_karatsuba_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (in_valid),
    .a     (data),
    .b     (weight_q),
    .low   (prod_low),
    .high  (prod_high),
    .trim  (prod_trim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_FULL;
      s1_sum   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= vmx_mode_e'(simd_mode);
        s1_sum  <= sum_in;
      end
    end
  end

  always_comb begin
    trim_wide = {{(DATA_W-1){1'b0}}, prod_trim};
    full_sum  = {prod_high, prod_low} + (trim_wide << H) + s1_sum;
    lane_lo   = prod_low + s1_sum[DATA_W-1:0];
    lane_hi   = prod_high + s1_sum[2*DATA_W-1:DATA_W];
    sum_next  = (s1_mode == MODE_SIMD2) ? {lane_hi, lane_lo} : full_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_valid <= 1'b0;
      sum_out   <= '0;
    end else begin
      sum_valid <= s1_valid;
      if (s1_valid) sum_out <= sum_next;
    end
  end

endmodule

// File: tb/tb_vmx_pe_karatsuba_pipe.sv
// Self-checking bench for vmx_pe_karatsuba_pipe (DATA_W=16, SEL_W=8) against a
// plain-arithmetic model, with literal expectations pinning key cases.
module tb_vmx_pe_karatsuba_pipe;

  localparam int DW = 16;
  localparam int SW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          simd_mode;
  logic [SW-1:0] is_weight;
  logic [DW-1:0] data;
  logic [2*DW-1:0] sum_in;
  logic          valid_pass;
  logic          simd_mode_pass;
  logic [SW-1:0] is_weight_pass;
  logic [DW-1:0] data_pass;
  logic [2*DW-1:0] sum_out;
  logic          sum_valid;
  logic          weight_loaded;

  vmx_pe_karatsuba_pipe #(.DATA_W(DW), .SEL_W(SW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .simd_mode      (simd_mode),
    .is_weight      (is_weight),
    .data           (data),
    .sum_in         (sum_in),
    .valid_pass     (valid_pass),
    .simd_mode_pass (simd_mode_pass),
    .is_weight_pass (is_weight_pass),
    .data_pass      (data_pass),
    .sum_out        (sum_out),
    .sum_valid      (sum_valid),
    .weight_loaded  (weight_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: stationary weight, one beat waiting for its result, and the
  // output values expected after the coming edge.
  logic [15:0] m_w;
  logic        m_loaded;
  logic        m1_valid;
  logic [31:0] m1_sum;
  logic        e_sum_valid;
  logic [31:0] e_sum;
  logic        e_vp, e_mp;
  logic [7:0]  e_iwp;
  logic [15:0] e_dp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_sum(input logic m, input logic [15:0] d,
                                            input logic [15:0] w, input logic [31:0] s);
    logic [15:0] lo, hi;
    if (!m) return 32'(d) * 32'(w) + s;
    lo = 16'(d[7:0]) * 16'(w[7:0]) + s[15:0];
    hi = 16'(d[15:8]) * 16'(w[15:8]) + s[31:16];
    return {hi, lo};
  endfunction

  task automatic model_clear();
    m_w = '0; m_loaded = 1'b0; m1_valid = 1'b0; m1_sum = '0;
    e_sum_valid = 1'b0; e_sum = '0;
    e_vp = 1'b0; e_mp = 1'b0; e_iwp = '0; e_dp = '0;
  endtask

  task automatic check_outputs();
    check("valid_pass", 32'(valid_pass), 32'(e_vp));
    check("simd_mode_pass", 32'(simd_mode_pass), 32'(e_mp));
    check("is_weight_pass", 32'(is_weight_pass), 32'(e_iwp));
    check("data_pass", 32'(data_pass), 32'(e_dp));
    check("weight_loaded", 32'(weight_loaded), 32'(m_loaded));
    check("sum_valid", 32'(sum_valid), 32'(e_sum_valid));
    check("sum_out", sum_out, e_sum);
  endtask

  task automatic step(input logic v, input logic m, input logic [7:0] iw,
                      input logic [15:0] d, input logic [31:0] s);
    in_valid = v; simd_mode = m; is_weight = iw; data = d; sum_in = s;
    e_sum_valid = m1_valid;
    if (m1_valid) e_sum = m1_sum;
    m1_valid = v;
    if (v) m1_sum = model_sum(m, d, m_w, s);
    if (v && iw == 8'h80) begin
      m_w = d;
      m_loaded = 1'b1;
    end
    e_vp = v; e_mp = m; e_dp = d;
    e_iwp = v ? iw - 8'd1 : iw;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sum_out"}, sum_out, 32'h0);
    check({tag, "_sum_valid"}, 32'(sum_valid), 32'h0);
    check({tag, "_valid_pass"}, 32'(valid_pass), 32'h0);
    check({tag, "_data_pass"}, 32'(data_pass), 32'h0);
    check({tag, "_is_weight_pass"}, 32'(is_weight_pass), 32'h0);
    check({tag, "_weight_loaded"}, 32'(weight_loaded), 32'h0);
    check({tag, "_simd_mode_pass"}, 32'(simd_mode_pass), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; simd_mode = 1'b0;
    is_weight = '0; data = '0; sum_in = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Weight load, then full-mode product with that weight
    step(1'b1, 1'b0, 8'h80, 16'h1234, 32'h0);
    check("load_iwp", 32'(is_weight_pass), 32'h7F);
    check("load_flag", 32'(weight_loaded), 32'h1);
    step(1'b1, 1'b0, 8'h05, 16'hFFFF, 32'h0);
    step(1'b0, 1'b0, 8'h05, 16'h0, 32'h0);
    check("full_sum", sum_out, 32'h1233EDCC);
    check("full_valid", 32'(sum_valid), 32'h1);

    // SIMD lanes
    step(1'b1, 1'b0, 8'h80, 16'h0302, 32'h0);
    step(1'b1, 1'b1, 8'h22, 16'h0504, 32'h0001_0002);
    step(1'b0, 1'b0, 8'h22, 16'h0, 32'h0);
    check("simd_sum", sum_out, 32'h0010_000A);

    // Wrap-around in both modes, back to back
    step(1'b1, 1'b0, 8'h80, 16'hFFFF, 32'h0);
    step(1'b1, 1'b0, 8'h10, 16'hFFFF, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 8'h10, 16'hFFFF, 32'hFFFF_FFFF);
    check("wrap_full", sum_out, 32'hFFFE0000);
    step(1'b0, 1'b0, 8'h10, 16'h0, 32'h0);
    check("wrap_simd", sum_out, 32'hFE00FE00);

    // Capture beat uses the old weight; bubble behaviour
    step(1'b1, 1'b0, 8'h80, 16'h0002, 32'h0);
    step(1'b1, 1'b0, 8'h80, 16'h0005, 32'h0);
    step(1'b0, 1'b0, 8'h33, 16'h0, 32'h0);
    check("bubble_iwp", 32'(is_weight_pass), 32'h33);
    check("capture_old_w", sum_out, 32'h0000_000A);
    step(1'b0, 1'b0, 8'h33, 16'h0, 32'h0);
    check("bubble_no_valid", 32'(sum_valid), 32'h0);
    check("bubble_hold", sum_out, 32'h0000_000A);
    step(1'b1, 1'b0, 8'h01, 16'h0003, 32'h0);
    step(1'b0, 1'b0, 8'h01, 16'h0, 32'h0);
    step(1'b0, 1'b0, 8'h01, 16'h0, 32'h0);
    check("new_w_applies", sum_out, 32'h0000_000F);

    // Randomized traffic, full throughput with mode changes and reloads
    for (int i = 0; i < 400; i++) begin
      logic [7:0] iw;
      iw = ($urandom_range(0, 4) == 0) ? 8'h80 : 8'($urandom);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), iw,
           16'($urandom), 32'($urandom));
    end

    // Reset with two beats in flight
    step(1'b1, 1'b0, 8'h01, 16'h0010, 32'h0);
    step(1'b1, 1'b1, 8'h01, 16'h0203, 32'h5);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 16'h0, 32'h0);
      check("post_rst_no_valid", 32'(sum_valid), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
